// File: rtl/instr_sequencer.sv
// Instruction sequencer: owns the PC, fetches from a synchronous ROM, issues
// each word to the datapath with a one-cycle Run pulse and waits for Done.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped, PC retained; Start (without Stop) resumes at PC
// FETCH | ROM address held stable until ROMData is valid, then captured
// ISSUE | Run pulse, watchdog loaded
// WAIT  | waiting for Done; PC and InstrCount advance on Done
// NEXT  | new PC on ROMAddr; honour a pending stop request
// HALT  | halt word fetched; only Start leaves (restart from PC 0)
// FAULT | watchdog expired; only Start leaves (restart from PC 0)
module instr_sequencer #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter int                ROM_LAT   = 1,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF,
  parameter int                TIMEOUT   = 255
) (
  input  logic              PClock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  input  logic [DATA_W-1:0] ROMData,
  input  logic              Done,
  input  logic              PCLoad,
  input  logic [ADDR_W-1:0] PCTarget,
  output logic [ADDR_W-1:0] ROMAddr,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Timeout,
  output logic [15:0]       InstrCount
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Down-counter reload values. A restart from HALT/FAULT clears the PC on the
  // same edge that enters FETCH, so the ROM sees the new address one cycle
  // later than on a normal fetch and needs one extra FETCH cycle.
  localparam logic [2:0]      LAT_FETCH   = 3'(ROM_LAT - 1);
  localparam logic [2:0]      LAT_RESTART = 3'(ROM_LAT);
  localparam logic [WD_W-1:0] WD_LOAD     = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_NEXT, S_HALT, S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [15:0]       count_q, count_d;
  logic              stop_q, stop_d;
  logic [2:0]        lat_q, lat_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              busy;

  assign busy = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                (state_q == S_WAIT)  || (state_q == S_NEXT);

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge PClock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      din_q   <= '0;
      count_q <= '0;
      stop_q  <= 1'b0;
      lat_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      count_q <= count_d;
      stop_q  <= stop_d;
      lat_q   <= lat_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state and datapath update decode.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din_d   = din_q;
    count_d = count_q;
    stop_d  = stop_q;
    lat_d   = lat_q;
    wd_d    = wd_q;
    if (busy && Stop) stop_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (Start && !Stop) begin
          state_d = S_FETCH;
          lat_d   = LAT_FETCH;
        end
      end
      S_FETCH: begin
        if (lat_q == '0) begin
          din_d   = ROMData;
          state_d = (ROMData == HALT_WORD) ? S_HALT : S_ISSUE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_ISSUE: begin
        wd_d    = WD_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Done) begin
          pc_d    = PCLoad ? PCTarget : pc_q + ADDR_W'(1);
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d = S_NEXT;
        end else if (wd_q == '0) begin
          state_d = S_FAULT;
        end else begin
          wd_d = wd_q - WD_W'(1);
        end
      end
      S_NEXT: begin
        // A Stop arriving in this very cycle is honoured as well.
        if (stop_q || Stop) begin
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
          lat_d   = LAT_FETCH;
        end
      end
      S_HALT, S_FAULT: begin
        if (Start) begin
          pc_d    = '0;
          count_d = '0;
          stop_d  = 1'b0;
          wd_d    = '0;
          lat_d   = LAT_RESTART;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ROMAddr    = pc_q;
  assign DIN        = din_q;
  assign InstrCount = count_q;
  assign Run        = (state_q == S_ISSUE);
  assign Busy       = busy;
  assign Halted     = (state_q == S_HALT);
  assign Timeout    = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed program scenarios with literal checks,
// then randomized control inputs, all shadowed by a behavioural model.
module tb_instr_sequencer;

  localparam int ROM_LAT = 1;
  localparam int TIMEOUT = 255;

  localparam int MI = 0, MF = 1, MS = 2, MW = 3, MN = 4, MH = 5, MT = 6;

  typedef struct {
    int          mode;
    logic [15:0] pc;
    logic [15:0] din;
    logic [15:0] cnt;
    bit          stop;
    int          left;
    int          waited;
  } mstate_t;

  logic        PClock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0, Stop = 1'b0, Done = 1'b0, PCLoad = 1'b0;
  logic [15:0] PCTarget = 16'h0;
  logic [15:0] ROMData, ROMAddr, DIN, InstrCount;
  logic        Run, Busy, Halted, Timeout;

  logic [15:0] rom [0:65535];
  logic [15:0] rom_pipe [ROM_LAT];
  logic [15:0] dins [$];
  mstate_t     m;
  bit          cmp_en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  instr_sequencer #(
    .ADDR_W(16), .DATA_W(16), .ROM_LAT(ROM_LAT),
    .HALT_WORD(16'hFFFF), .TIMEOUT(TIMEOUT)
  ) dut (
    .PClock(PClock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
    .ROMData(ROMData), .Done(Done), .PCLoad(PCLoad), .PCTarget(PCTarget),
    .ROMAddr(ROMAddr), .DIN(DIN), .Run(Run), .Busy(Busy),
    .Halted(Halted), .Timeout(Timeout), .InstrCount(InstrCount)
  );

  always #5 PClock = ~PClock;

  // Synchronous ROM: data is ROM_LAT register stages behind the address.
  always @(posedge PClock) begin
    rom_pipe[0] <= rom[ROMAddr];
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign ROMData = rom_pipe[ROM_LAT-1];

  function automatic mstate_t model_reset();
    mstate_t r;
    r.mode = MI; r.pc = '0; r.din = '0; r.cnt = '0;
    r.stop = 1'b0; r.left = 0; r.waited = 0;
    return r;
  endfunction

  // One clock of the sequencing rules, written from the operational description.
  function automatic mstate_t model_step(input mstate_t s, input logic start,
      input logic stop, input logic done, input logic load,
      input logic [15:0] tgt, input logic [15:0] word);
    mstate_t n = s;
    if (stop && (s.mode == MF || s.mode == MS || s.mode == MW || s.mode == MN))
      n.stop = 1'b1;
    case (s.mode)
      MI: if (start && !stop) begin n.mode = MF; n.left = ROM_LAT; end
      MF: begin
        if (s.left == 1) begin
          n.din  = word;
          n.mode = (word == 16'hFFFF) ? MH : MS;
        end else n.left = s.left - 1;
      end
      MS: begin n.waited = 0; n.mode = MW; end
      MW: begin
        if (done) begin
          n.pc   = load ? tgt : s.pc + 16'd1;
          n.cnt  = (s.cnt == 16'hFFFF) ? s.cnt : s.cnt + 16'd1;
          n.mode = MN;
        end else begin
          n.waited = s.waited + 1;
          if (n.waited == TIMEOUT) n.mode = MT;
        end
      end
      MN: begin
        if (n.stop) begin n.stop = 1'b0; n.mode = MI; end
        else begin n.mode = MF; n.left = ROM_LAT; end
      end
      default: begin
        if (start) begin
          n.pc = '0; n.cnt = '0; n.stop = 1'b0;
          n.mode = MF; n.left = ROM_LAT + 1;
        end
      end
    endcase
    return n;
  endfunction

  // Model register, reset asynchronously like the design.
  always @(posedge PClock or negedge Resetn) begin
    if (!Resetn) m <= model_reset();
    else m <= model_step(m, Start, Stop, Done, PCLoad, PCTarget, ROMData);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge PClock);
      if (cmp_en) begin
        chk("ROMAddr", ROMAddr, m.pc);
        chk("DIN", DIN, m.din);
        chk("InstrCount", InstrCount, m.cnt);
        chk("Run", Run, m.mode == MS);
        chk("Busy", Busy, m.mode == MF || m.mode == MS || m.mode == MW || m.mode == MN);
        chk("Halted", Halted, m.mode == MH);
        chk("Timeout", Timeout, m.mode == MT);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  task automatic do_reset();
    Start = 0; Stop = 0; Done = 0; PCLoad = 0; PCTarget = 0;
    #2 Resetn = 0;
    repeat (2) @(negedge PClock);
    #2 Resetn = 1;
    @(negedge PClock);
  endtask

  // Pulse Start, answer each Run with Done one cycle later, optionally jump or
  // stop at a given PC, and return once the block leaves the busy states.
  task automatic run_prog(input int budget, input int jump_pc, input logic [15:0] jump_tgt,
      input int stop_pc, input int done_limit,
      output int runs, output int first_run, output int since);
    bit want_done = 0;
    bit ended = 0;
    runs = 0; first_run = -1; since = 0;
    dins.delete();
    Start = 1;
    for (int it = 1; it <= budget; it++) begin
      @(negedge PClock);
      Start = 0; Done = 0; PCLoad = 0; Stop = 0;
      if (want_done) begin
        Done = 1;
        if (int'(ROMAddr) == jump_pc) begin PCLoad = 1; PCTarget = jump_tgt; end
        if (int'(ROMAddr) == stop_pc) Stop = 1;
        want_done = 0;
      end
      if (Run) begin
        runs++;
        if (first_run < 0) first_run = it;
        dins.push_back(DIN);
        since = 0;
        want_done = (done_limit < 0) || (runs <= done_limit);
      end else since++;
      if (!Busy) begin ended = 1; break; end
    end
    Done = 0; PCLoad = 0; Stop = 0;
    chk("prog_ends", ended, 1);
  endtask

  initial begin
    int runs, first_run, since;
    bit seen;
    bit want;
    for (int a = 0; a < 65536; a++) rom[a] = 16'h0000;

    do_reset();
    cmp_en = 1;
    chk("reset_ROMAddr", ROMAddr, 16'h0);
    chk("reset_Busy", Busy, 0);

    // Basic program: two instructions then the halt word.
    rom[0] = 16'h1000; rom[1] = 16'h2000; rom[2] = 16'hFFFF;
    run_prog(60, -1, 16'h0, -1, -1, runs, first_run, since);
    chk("basic_runs", runs, 2);
    chk("basic_first_run_cycle", first_run, ROM_LAT + 1);
    if (dins.size() == 2) begin
      chk("basic_din0", dins[0], 16'h1000);
      chk("basic_din1", dins[1], 16'h2000);
    end
    chk("basic_halted", Halted, 1);
    chk("basic_addr", ROMAddr, 16'h0002);
    chk("basic_count", InstrCount, 16'h0002);

    // Jump from PC 1 to 0x40; address 2 must never be issued.
    do_reset();
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333;
    rom[16'h40] = 16'h4444; rom[16'h41] = 16'hFFFF;
    run_prog(60, 1, 16'h0040, -1, -1, runs, first_run, since);
    chk("jump_runs", runs, 3);
    if (dins.size() == 3) chk("jump_din2", dins[2], 16'h4444);
    chk("jump_addr", ROMAddr, 16'h0041);
    chk("jump_count", InstrCount, 16'h0003);

    // Stop during WAIT of PC 5, then resume at PC 6.
    do_reset();
    for (int a = 0; a < 8; a++) rom[a] = 16'h0100 + 16'(a);
    rom[7] = 16'hFFFF;
    run_prog(100, -1, 16'h0, 5, -1, runs, first_run, since);
    chk("stop_runs", runs, 6);
    chk("stop_addr", ROMAddr, 16'h0006);
    chk("stop_count", InstrCount, 16'h0006);
    chk("stop_idle", Busy | Halted, 0);
    run_prog(60, -1, 16'h0, -1, -1, runs, first_run, since);
    chk("resume_runs", runs, 1);
    if (dins.size() == 1) chk("resume_din", dins[0], 16'h0106);
    chk("resume_halted", Halted, 1);

    // Watchdog: first instruction completes, second never gets Done.
    do_reset();
    rom[0] = 16'h1234; rom[1] = 16'h5678;
    run_prog(400, -1, 16'h0, -1, 1, runs, first_run, since);
    chk("wd_runs", runs, 2);
    chk("wd_cycles_after_run", since, TIMEOUT + 1);
    chk("wd_timeout", Timeout, 1);
    chk("wd_addr", ROMAddr, 16'h0001);
    chk("wd_count", InstrCount, 16'h0001);
    Start = 1;
    @(negedge PClock);
    Start = 0;
    chk("wd_restart_addr", ROMAddr, 16'h0000);
    chk("wd_restart_count", InstrCount, 16'h0000);
    chk("wd_restart_busy", Busy, 1);

    // PC wrap: jump to 0xFFFF, then sequential advance wraps to 0.
    do_reset();
    rom[0] = 16'h0AAA; rom[16'hFFFF] = 16'h0BBB;
    run_prog(60, 0, 16'hFFFF, 65535, -1, runs, first_run, since);
    chk("wrap_runs", runs, 2);
    if (dins.size() == 2) chk("wrap_din1", dins[1], 16'h0BBB);
    chk("wrap_addr", ROMAddr, 16'h0000);
    chk("wrap_count", InstrCount, 16'h0002);

    // Reset while Run is high on the second instruction.
    do_reset();
    rom[0] = 16'h0101; rom[1] = 16'h0202; rom[2] = 16'hFFFF;
    seen = 0; want = 0;
    Start = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge PClock);
      Start = 0;
      Done = want;
      want = 0;
      if (Run && ROMAddr == 16'h0001) begin seen = 1; break; end
      if (Run) want = 1;
    end
    Done = 0;
    chk("rst_saw_run_pc1", seen, 1);
    chk("rst_pre_count", InstrCount, 16'h0001);
    #2 Resetn = 0;
    #1;
    chk("rst_run", Run, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_addr", ROMAddr, 16'h0000);
    chk("rst_count", InstrCount, 16'h0000);
    #1 Resetn = 1;
    Start = 1; Stop = 1;
    repeat (4) begin
      @(negedge PClock);
      chk("start_stop_busy", Busy, 0);
      chk("start_stop_run", Run, 0);
    end
    Stop = 0;
    @(negedge PClock);
    Start = 0;
    chk("start_after_stop_busy", Busy, 1);

    // Randomized control traffic over a random program image.
    for (int a = 0; a < 65536; a++)
      rom[a] = ($urandom % 10 == 0) ? 16'hFFFF : 16'($urandom);
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge PClock);
      Start = ($urandom % 8 == 0);
      Stop = ($urandom % 24 == 0);
      Done = ($urandom % 3 == 0);
      PCLoad = ($urandom % 4 == 0);
      PCTarget = 16'($urandom % 300);
    end
    // Sparse Done so the watchdog fires from time to time.
    for (int c = 0; c < 3000; c++) begin
      @(negedge PClock);
      Start = ($urandom % 6 == 0);
      Stop = ($urandom % 40 == 0);
      Done = ($urandom % 150 == 0);
      PCLoad = ($urandom % 3 == 0);
      PCTarget = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
    end
    Start = 0; Stop = 0; Done = 0; PCLoad = 0;
    @(negedge PClock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Single-clock controller that sequences the processor datapath. It owns the program counter and drives the synchronous instruction ROM address. It captures each fetched word and presents it on `DIN` with a one-cycle `Run` pulse, then waits for `Done` before advancing. It replaces manual `Run` toggling, and adds jump support, halt-word detection, a stop request and a `Done` watchdog.

## Interface
Parameters:
- `ADDR_W`, default 16: width of the PC and of `ROMAddr`.
- `DATA_W`, default 16: instruction width.
- `ROM_LAT`, default 1: number of cycles from a `ROMAddr` change until `ROMData` is valid. Legal range is 1..4.
- `HALT_WORD`, default 16'hFFFF: instruction word that halts sequencing. It is never issued to the processor.
- `TIMEOUT`, default 255: maximum number of `WAIT` cycles allowed without `Done`.

Ports:
- `PClock` in 1: clock. All state changes on the rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `Start` in 1: level sampled each cycle; begin or resume execution.
- `Stop` in 1: level sampled each cycle; stop after the current instruction.
- `ROMData` in DATA_W: instruction ROM output.
- `Done` in 1: processor has completed the instruction.
- `PCLoad` in 1: jump request, valid only in the cycle `Done`=1.
- `PCTarget` in ADDR_W: jump destination, qualified by `PCLoad`.
- `ROMAddr` out ADDR_W: current PC; it is the registered PC, not combinational.
- `DIN` out DATA_W: captured instruction. Held stable from `ISSUE` through `WAIT`.
- `Run` out 1: high for exactly one cycle per issued instruction.
- `Busy` out 1: high in `FETCH`, `ISSUE`, `WAIT` and `NEXT`.
- `Halted` out 1: high in `HALT`.
- `Timeout` out 1: high in `FAULT`.
- `InstrCount` out 16: number of completed instructions; saturates at 16'hFFFF.

## Operation
- Reset values: state `IDLE`, PC=0, `DIN`=0, `InstrCount`=0, all 1-bit outputs 0, stop flag 0, latency and watchdog counters 0.
- States and transitions:
  - `IDLE`: `Start`=1 and `Stop`=0 → `FETCH`. If `Start` and `Stop` are both high, `Stop` wins and the block stays in `IDLE`. PC is retained, so a later `Start` resumes at the current PC.
  - `FETCH`: wait ROM_LAT cycles. On the last cycle, register `ROMData` into `DIN`. If the word equals HALT_WORD → `HALT`; otherwise → `ISSUE`.
  - `ISSUE`: `Run`=1 for this single cycle; clear the watchdog; → `WAIT`.
  - `WAIT`: when `Done`=1 → `NEXT`, and in the same edge set PC to `PCLoad ? PCTarget : PC+1` and increment `InstrCount`. When the watchdog reaches TIMEOUT with `Done`=0 → `FAULT`.
  - `NEXT`: if the stop flag is set → `IDLE` and clear the stop flag; otherwise → `FETCH`.
  - `HALT` and `FAULT`: the only exit is `Start`=1, which clears PC, `InstrCount` and the flags, then goes → `FETCH`.
- Stop flag: set when `Stop`=1 in any `Busy` state. It is sticky until consumed in `NEXT`. An in-flight instruction always completes.
- `Start` is ignored while `Busy`.
- `Done` is ignored outside `WAIT`. A `Done` in `ISSUE` is not recorded.
- PC arithmetic is modulo 2^ADDR_W: PC+1 at all-ones wraps to 0. `PCTarget` is taken as-is.
- `InstrCount` holds at 16'hFFFF with no wrap.
- `Resetn` low mid-instruction forces all reset values immediately, including `Run`=0. No instruction is completed or counted.

## Timing
- `Start` sampled at edge 0 → `FETCH` for cycles 1..ROM_LAT → `Run`=1 in cycle ROM_LAT+1. With ROM_LAT=1, `Run` is high in cycle 2.
- Earliest `Done` is the cycle after `Run`.
- `Done` at cycle t → new `ROMAddr` visible at t+1 (`NEXT`) → next `Run` at t+2+ROM_LAT.
- Minimum issue period is ROM_LAT+3 cycles with immediate `Done`.
- `ROMAddr` is stable for the whole of `FETCH`, so the ROM sees a constant address for ROM_LAT cycles.
- `Timeout` rises TIMEOUT+1 cycles after `Run` if no `Done` arrives.

## Test plan
- Program 0x1000, 0x2000, 0xFFFF at addresses 0..2; ROM_LAT=1; `Done` returned 1 cycle after each `Run` → exactly two `Run` pulses, `DIN`=0x1000 then 0x2000, then `Halted`=1 with `ROMAddr`=2 and `InstrCount`=2.
- Jump: at PC=1 drive `Done`=1, `PCLoad`=1, `PCTarget`=0x0040 → next `ROMAddr`=0x0040 and no fetch from address 2.
- Stop: assert `Stop` for one cycle during `WAIT` of PC=5 → the instruction completes, `InstrCount` increments, state goes to `IDLE` with PC=6 and no further `Run`. A following `Start` produces `Run` with `DIN`=ROM[6].
- Watchdog with TIMEOUT=255: never assert `Done` → `Timeout`=1 exactly 256 cycles after `Run` and `Busy`=0. A subsequent `Start` restarts at PC=0 with `InstrCount`=0.
- Wrap: PCLoad to 0xFFFF, then `Done` with `PCLoad`=0 → `ROMAddr`=0x0000.
- Reset: drop `Resetn` while `Run`=1 → `Run`, `Busy`, PC and `InstrCount` go to 0 immediately; `Start` and `Stop` high together in `IDLE` → the block remains in `IDLE`.
